// File: rtl/gost89_cfb_decrypt_stream_pkg.sv
// Shared widths, FSM encoding and byte-count helpers for the GOST 28147-89 CFB receive path.
package gost89_pkg;

  localparam int BLK_W  = 64;
  localparam int KEY_W  = 256;
  localparam int SBOX_W = 512;

  typedef enum logic [1:0] {NOIV, READY, RUN, DONE} state_e;

  // Only a last block may be short; 0 or anything above 8 means a full block.
  function automatic logic [3:0] norm_nbytes(input logic [3:0] nbytes, input logic last);
    return (!last || nbytes == 4'd0 || nbytes > 4'd8) ? 4'd8 : nbytes;
  endfunction

  function automatic logic [BLK_W-1:0] byte_mask(input logic [3:0] nbytes);
    logic [BLK_W-1:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      if (4'(i) < nbytes) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

endpackage

// File: rtl/gost89_cfb_decrypt_stream_if.sv
// IV load, ciphertext input and plaintext output handshakes of the CFB decryptor.
interface gost89_cfb_decrypt_stream_if;
  import gost89_pkg::*;

  logic [BLK_W-1:0] iv;
  logic             iv_load;
  logic             iv_ready;
  logic [BLK_W-1:0] in_data;
  logic [3:0]       in_nbytes;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic [BLK_W-1:0] out_data;
  logic [3:0]       out_nbytes;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output iv, iv_load, in_data, in_nbytes, in_last, in_valid, out_ready,
    input  iv_ready, in_ready, out_data, out_nbytes, out_last, out_valid
  );

  modport slave (
    input  iv, iv_load, in_data, in_nbytes, in_last, in_valid, out_ready,
    output iv_ready, in_ready, out_data, out_nbytes, out_last, out_valid
  );

endinterface

// File: rtl/gost89_cfb_decrypt_stream_ecb.sv
// GOST 28147-89 ECB encryption core: one Feistel round per clock, 32 rounds per block.
module gost89_ecb_encrypt
  import gost89_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_data_i,
  input  logic [BLK_W-1:0]  data_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic [SBOX_W-1:0] sbox_i,
  output logic [BLK_W-1:0]  data_o,
  output logic              busy_o
);

  logic [31:0] n1_q, n1_d, n2_q, n2_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        busy_q, busy_d;
  logic [2:0]  kidx;
  logic [31:0] sum, sub, f;

  // Key words run K0..K7 three times, then K7..K0 for the final eight rounds.
  always_comb begin
    kidx = (rnd_q < 5'd24) ? rnd_q[2:0] : ~rnd_q[2:0];
    sum  = n1_q + key_i[{kidx, 5'd0} +: 32];
    sub  = '0;
    for (int j = 0; j < 8; j++)
      sub[4*j +: 4] = sbox_i[{3'(j), sum[4*j +: 4], 2'b00} +: 4];
    f = {sub[20:0], sub[31:21]};
  end

  // Load takes priority over reset so a reset+load pulse restarts the core cleanly.
  always_comb begin
    n1_d   = n1_q;
    n2_d   = n2_q;
    rnd_d  = rnd_q;
    busy_d = busy_q;
    if (load_data_i) begin
      n1_d   = data_i[31:0];
      n2_d   = data_i[63:32];
      rnd_d  = '0;
      busy_d = 1'b1;
    end else if (reset) begin
      n1_d   = '0;
      n2_d   = '0;
      rnd_d  = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      n1_d   = n2_q ^ f;
      n2_d   = n1_q;
      rnd_d  = rnd_q + 5'd1;
      busy_d = (rnd_q != 5'd31);
    end
  end

  always_ff @(posedge clk) begin
    n1_q   <= n1_d;
    n2_q   <= n2_d;
    rnd_q  <= rnd_d;
    busy_q <= busy_d;
  end

  // Every round swaps halves, so the final no-swap round is undone by ordering here.
  assign data_o = {n1_q, n2_q};
  assign busy_o = busy_q;

endmodule

// File: rtl/gost89_cfb_decrypt_stream.sv
// CFB stream decryptor: gamma = E(previous ciphertext), one block of lookahead behind the output register.
module gost89_cfb_decrypt_stream
  import gost89_pkg::*;
#(
  parameter bit ZERO_PAD = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SBOX_W-1:0]          sbox,
  input  logic [KEY_W-1:0]           key,
  gost89_cfb_decrypt_stream_if.slave bus,
  output logic                       busy
);

  state_e           state_q, state_d;
  logic [BLK_W-1:0] gamma_q, cin_q, core_out, plain;
  logic [3:0]       nb_q;
  logic             last_q;
  logic [BLK_W-1:0] out_data_q;
  logic [3:0]       out_nbytes_q;
  logic             out_last_q, out_valid_q;
  logic             core_busy, iv_rdy, iv_acc, in_rdy, start;
  logic             out_free, res_rdy, load_out;

  gost89_ecb_encrypt u_ecb (
    .clk         (clk),
    .reset       (reset | start),
    .load_data_i (start),
    .data_i      (gamma_q),
    .key_i       (key),
    .sbox_i      (sbox),
    .data_o      (core_out),
    .busy_o      (core_busy)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= NOIV;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      NOIV:  if (iv_acc) state_d = READY;
      READY: if (start) state_d = RUN;
      RUN:   if (!core_busy) state_d = out_free ? (last_q ? NOIV : READY) : DONE;
      DONE:  if (out_free) state_d = last_q ? NOIV : READY;
      default: state_d = NOIV;
    endcase
  end

  // An accepted iv_load in READY blocks the input handshake for that cycle.
  always_comb begin
    iv_rdy   = (state_q == NOIV || state_q == READY) && !out_valid_q;
    iv_acc   = bus.iv_load && iv_rdy;
    in_rdy   = (state_q == READY) && !iv_acc;
    start    = bus.in_valid && in_rdy && !reset;
    out_free = !out_valid_q || bus.out_ready;
    res_rdy  = (state_q == RUN && !core_busy) || state_q == DONE;
    load_out = res_rdy && out_free;
    busy     = (state_q == RUN) || (state_q == DONE);
  end

  // Ciphertext becomes the next gamma even for a short last block; it is simply never used.
  always_ff @(posedge clk) begin
    if (reset) begin
      gamma_q <= '0;
      cin_q   <= '0;
      nb_q    <= '0;
      last_q  <= 1'b0;
    end else if (iv_acc) begin
      gamma_q <= bus.iv;
    end else if (start) begin
      gamma_q <= bus.in_data;
      cin_q   <= bus.in_data;
      nb_q    <= norm_nbytes(bus.in_nbytes, bus.in_last);
      last_q  <= bus.in_last;
    end
  end

  assign plain = ZERO_PAD ? ((core_out ^ cin_q) & byte_mask(nb_q)) : (core_out ^ cin_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q   <= '0;
      out_nbytes_q <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
    end else if (load_out) begin
      out_data_q   <= plain;
      out_nbytes_q <= nb_q;
      out_last_q   <= last_q;
      out_valid_q  <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  assign bus.iv_ready   = iv_rdy;
  assign bus.in_ready   = in_rdy;
  assign bus.out_data   = out_data_q;
  assign bus.out_nbytes = out_nbytes_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_valid  = out_valid_q;

endmodule

// File: tb/tb_gost89_cfb_decrypt_stream.sv
// Self-checking bench: CFB encryptor + GOST reference model feed ciphertext, a scoreboard checks plaintext.
module tb_gost89_cfb_decrypt_stream;
  import gost89_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [SBOX_W-1:0] sbox;
  logic [KEY_W-1:0]  key;
  logic              busy;

  gost89_cfb_decrypt_stream_if bus ();

  gost89_cfb_decrypt_stream #(.ZERO_PAD(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .sbox  (sbox),
    .key   (key),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] data; logic [3:0] nb; logic last; } exp_t;
  typedef struct { logic [63:0] pt; logic [3:0] nb; logic last; logic [3:0] exp_nb; } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  exp_t        expq[$];
  logic [63:0] gamma_m;
  bit          rnd_ready = 0;
  vec_t        tbl[6];

  localparam logic [63:0] IV1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] PT0 = 64'h0011223344556677;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Textbook form: 31 rounds with swap, last round without, result {N2,N1}.
  function automatic logic [63:0] gost_enc(input logic [63:0] blk);
    logic [31:0] a, b, t, s;
    int ki;
    a = blk[31:0];
    b = blk[63:32];
    for (int r = 0; r < 32; r++) begin
      ki = (r < 24) ? (r % 8) : (7 - (r % 8));
      t  = a + key[32*ki +: 32];
      for (int j = 0; j < 8; j++) s[4*j +: 4] = sbox[64*j + 4*t[4*j +: 4] +: 4];
      s = (s << 11) | (s >> 21);
      if (r == 31) b = b ^ s;
      else begin
        t = b ^ s;
        b = a;
        a = t;
      end
    end
    return {b, a};
  endfunction

  function automatic logic [63:0] keep_bytes(input logic [63:0] d, input int n);
    logic [63:0] r;
    r = d;
    for (int i = 0; i < 8; i++) if (i >= n) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  function automatic logic [3:0] model_nb(input logic [3:0] nb, input logic last);
    if (last && nb >= 4'd1 && nb <= 4'd8) return nb;
    return 4'd8;
  endfunction

  // Scoreboard: a beat seen with valid&&ready here is consumed at the next posedge.
  initial begin
    logic        hold;
    logic [63:0] hd;
    logic [3:0]  hn;
    logic        hl;
    exp_t        e;
    hold = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) hold = 0;
      else begin
        if (hold) begin
          check("hold_valid", 64'(bus.out_valid), 64'd1);
          check("hold_data", bus.out_data, hd);
          check("hold_nbytes", 64'(bus.out_nbytes), 64'(hn));
          check("hold_last", 64'(bus.out_last), 64'(hl));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (expq.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL out_extra: got unexpected block %h, expected none", bus.out_data);
          end else begin
            e = expq.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_nbytes", 64'(bus.out_nbytes), 64'(e.nb));
            check("out_last", 64'(bus.out_last), 64'(e.last));
          end
        end
        hold = bus.out_valid && !bus.out_ready;
        hd = bus.out_data;
        hn = bus.out_nbytes;
        hl = bus.out_last;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic load_iv(input logic [63:0] v);
    bus.iv = v;
    bus.iv_load = 1'b1;
    #1;
    check("iv_ready", 64'(bus.iv_ready), 64'd1);
    @(negedge clk);
    bus.iv_load = 1'b0;
    gamma_m = v;
  endtask

  task automatic send(input logic [63:0] pt, input logic [3:0] nb, input logic last,
                      input logic [3:0] exp_nb);
    logic [63:0] ct;
    exp_t        e;
    int          w;
    ct = pt ^ gost_enc(gamma_m);
    bus.in_data = ct;
    bus.in_nbytes = nb;
    bus.in_last = last;
    bus.in_valid = 1'b1;
    w = 0;
    #1;
    while (!bus.in_ready && w < 400) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("in_accept", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) begin
      e.data = keep_bytes(pt, int'(exp_nb));
      e.nb = exp_nb;
      e.last = last;
      expq.push_back(e);
      gamma_m = ct;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((expq.size() != 0 || bus.out_valid) && w < 800) begin
      @(negedge clk);
      #2;
      w++;
    end
    check("drain_pending", 64'(expq.size()), 64'd0);
  endtask

  task automatic stall_after_last();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #2;
      check("in_ready_after_last", 64'(bus.in_ready), 64'd0);
    end
    check("idle_after_last", 64'(busy), 64'd0);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    logic [3:0]  nb;
    logic [63:0] ivb;
    int          len, seen;

    sbox = {16{$urandom}};
    key = {8{$urandom}};
    for (int i = 0; i < 16; i++) sbox[32*i +: 32] = $urandom;
    for (int i = 0; i < 8; i++) key[32*i +: 32] = $urandom;
    bus.iv = '0; bus.iv_load = 0; bus.in_data = '0; bus.in_nbytes = '0;
    bus.in_last = 0; bus.in_valid = 0; bus.out_ready = 0;
    gamma_m = '0;

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_nbytes", 64'(bus.out_nbytes), 64'd0);
    check("rst_out_last", 64'(bus.out_last), 64'd0);
    check("rst_iv_ready", 64'(bus.iv_ready), 64'd1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;

    // Vector table: 4-block stream, 3-byte last block, nbytes=0 last block
    for (int i = 0; i < 4; i++) tbl[i] = '{PT0 + 64'(i), 4'd8, (i == 3), 4'd8};
    tbl[4] = '{64'hA1B2C3D4E5F60718, 4'd3, 1'b1, 4'd3};
    tbl[5] = '{64'h8877665544332211, 4'd0, 1'b1, 4'd8};
    for (int v = 0; v < 6; v++) begin
      if (v == 0) load_iv(IV1);
      else if (tbl[v-1].last) begin
        drain();
        stall_after_last();
        load_iv({$urandom, $urandom});
      end
      send(tbl[v].pt, tbl[v].nb, tbl[v].last, tbl[v].exp_nb);
    end
    drain();
    stall_after_last();

    // Output back-pressure for 100 cycles with one block of lookahead
    @(negedge clk);
    bus.out_ready = 1'b0;
    load_iv(IV1);
    fork
      begin
        for (int i = 0; i < 4; i++) send(PT0 + 64'(i), 4'd8, (i == 3), 4'd8);
      end
      begin
        repeat (100) @(negedge clk);
        #2;
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        check("stall_out_valid", 64'(bus.out_valid), 64'd1);
        check("stall_busy", 64'(busy), 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // iv_load and in_valid together: IV wins, block taken next cycle under the new IV
    @(negedge clk);
    load_iv(IV1);
    ivb = 64'hFEDCBA9876543210;
    bus.iv = ivb;
    bus.iv_load = 1'b1;
    bus.in_data = 64'h5555AAAA5555AAAA;
    bus.in_nbytes = 4'd8;
    bus.in_last = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check("iv_wins_in_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    bus.iv_load = 1'b0;
    gamma_m = ivb;
    #1;
    check("blk_after_iv_in_ready", 64'(bus.in_ready), 64'd1);
    send(64'h0F1E2D3C4B5A6978, 4'd8, 1'b1, 4'd8);
    drain();

    // Reset 10 cycles into RUN aborts the block
    @(negedge clk);
    load_iv(IV1);
    send(PT0, 4'd8, 1'b0, 4'd8);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expq.delete();
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      if (bus.out_valid) seen++;
    end
    check("abort_out_valid", 64'(seen), 64'd0);
    check("abort_iv_ready", 64'(bus.iv_ready), 64'd1);
    check("abort_in_ready", 64'(bus.in_ready), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    load_iv(IV1);
    send(PT0 + 64'd7, 4'd8, 1'b0, 4'd8);
    send(PT0 + 64'd8, 4'd5, 1'b1, 4'd5);
    drain();

    // Random messages, random byte counts, random out_ready
    rnd_ready = 1;
    for (int m = 0; m < 6; m++) begin
      load_iv({$urandom, $urandom});
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        nb = 4'($urandom_range(0, 15));
        send({$urandom, $urandom}, nb, (b == len - 1), model_nb(nb, (b == len - 1)));
      end
      drain();
    end
    rnd_ready = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
